// File: rtl/mem_sweep_responder_pkg.sv
// Shared state codes and counter widths for the memory sweep responder.
// Imported by the interface-facing top and the RAM sub-module.
package mem_sweep_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_GAP   = 3'd3,
        ST_XFER  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/mem_sweep_responder_if.sv
// Sweep handshake between the memory tester (master) and a memory-side responder (slave).
// The tester pulses start with rnw; the responder strobes ready once per word and pulses done at the end.
interface mem_sweep_responder_if #(
    parameter int DATA_W = 16
);
    // start is a one-cycle request seen only while busy=0; each ready cycle either consumes
    // wdat (write sweep) or presents valid rdat (read sweep); done follows the last ready.
    logic              start;
    logic              rnw;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] rdat;
    logic              ready;
    logic              done;
    logic              busy;
    logic [2:0]        state;

    modport master (
        output start, rnw, wdat,
        input  rdat, ready, done, busy, state
    );

    modport slave (
        input  start, rnw, wdat,
        output rdat, ready, done, busy, state
    );

endinterface

// File: rtl/mem_sweep_responder_ram.sv
// Single-port synchronous RAM with one-cycle read latency; init, write and read sweeps
// never overlap, so one port serves all of them.
module sweep_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_sweep_responder.sv
// Memory-side responder for the tester sweep handshake, backed by on-chip RAM.
// Define FAULT_INJECT_EN to invert rdat[FAULT_BIT] when reading FAULT_ADDR.
module mem_sweep_responder
    import mem_sweep_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int GAP        = 2,
    parameter int FAULT_ADDR = 0,
    parameter int FAULT_BIT  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_sweep_responder_if.slave  bus
);

`ifdef FAULT_INJECT_EN
    localparam bit FAULT_ON = 1'b1;
`else
    localparam bit FAULT_ON = 1'b0;
`endif

    localparam logic [ADDR_W-1:0]    LAST_ADDR  = '1;
    localparam logic [GAP_CNT_W-1:0] GAP_CNT    = GAP_CNT_W'(GAP);
    localparam logic [ADDR_W-1:0]    FAULT_A    = ADDR_W'(FAULT_ADDR);
    localparam logic [DATA_W-1:0]    FAULT_MASK = DATA_W'(1) << FAULT_BIT;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [GAP_CNT_W-1:0]   gap_q, gap_d;
    logic                   rnw_q, rnw_d;
    logic [DATA_W-1:0]      rdat_hold_q;

    logic                   ram_we;
    logic [DATA_W-1:0]      ram_wdata;
    logic [DATA_W-1:0]      ram_rdata;
    logic [DATA_W-1:0]      rd_word;
    logic                   rd_strobe;

    sweep_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            addr_q  <= '0;
            gap_q   <= '0;
            rnw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            gap_q   <= gap_d;
            rnw_q   <= rnw_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        gap_d     = gap_q;
        rnw_d     = rnw_q;
        ram_we    = 1'b0;
        ram_wdata = bus.wdat;
        case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_wdata = '0;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.start) begin
                    rnw_d   = bus.rnw;
                    addr_d  = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // The RAM samples addr_q here, so its output is valid by XFER even with GAP=0.
                gap_d   = GAP_CNT;
                state_d = (GAP_CNT == '0) ? ST_XFER : ST_GAP;
            end
            ST_GAP: begin
                gap_d = gap_q - GAP_CNT_W'(1);
                if (gap_q <= GAP_CNT_W'(1)) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                ram_we = !rnw_q;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    gap_d   = GAP_CNT;
                    state_d = ST_SETUP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The fault only touches the read path, so stored data stays clean and the error repeats each pass.
    assign rd_word   = ram_rdata ^ ((FAULT_ON && (addr_q == FAULT_A)) ? FAULT_MASK : '0);
    assign rd_strobe = (state_q == ST_XFER) && rnw_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdat_hold_q <= '0;
        end else if (rd_strobe) begin
            rdat_hold_q <= rd_word;
        end
    end

    assign bus.rdat  = rd_strobe ? rd_word : rdat_hold_q;
    assign bus.ready = (state_q == ST_XFER);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.state = state_q;

endmodule

// File: tb/tb_mem_sweep_responder.sv
// Directed bench for mem_sweep_responder: one GAP=1 and one GAP=0 instance, ADDR_W=4.
// Expected read data comes from a bench-side record of what each write sweep drove.
module tb_mem_sweep_responder;
    import mem_sweep_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int FA    = 5;

`ifdef FAULT_INJECT_EN
    localparam bit FAULT_ON = 1'b1;
`else
    localparam bit FAULT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_sweep_responder_if #(.DATA_W(DW)) bus1 ();
    mem_sweep_responder_if #(.DATA_W(DW)) bus0 ();

    mem_sweep_responder #(
        .DATA_W(DW), .ADDR_W(AW), .GAP(1), .FAULT_ADDR(FA), .FAULT_BIT(3)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    mem_sweep_responder #(
        .DATA_W(DW), .ADDR_W(AW), .GAP(0), .FAULT_ADDR(FA), .FAULT_BIT(3)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    logic            start_v [2];
    logic            rnw_v;
    logic [DW-1:0]   wdat_v;
    logic            ready_o [2];
    logic            done_o  [2];
    logic            busy_o  [2];
    logic [DW-1:0]   rdat_o  [2];
    logic [2:0]      state_o [2];

    assign bus1.start = start_v[1];
    assign bus0.start = start_v[0];
    assign bus1.rnw   = rnw_v;
    assign bus0.rnw   = rnw_v;
    assign bus1.wdat  = wdat_v;
    assign bus0.wdat  = wdat_v;
    assign ready_o[1] = bus1.ready;
    assign ready_o[0] = bus0.ready;
    assign done_o[1]  = bus1.done;
    assign done_o[0]  = bus0.done;
    assign busy_o[1]  = bus1.busy;
    assign busy_o[0]  = bus0.busy;
    assign rdat_o[1]  = bus1.rdat;
    assign rdat_o[0]  = bus0.rdat;
    assign state_o[1] = bus1.state;
    assign state_o[0] = bus0.state;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input int sel);
        check("rst_state", state_o[sel], ST_INIT);
        check("rst_busy", busy_o[sel], 1);
        check("rst_ready", ready_o[sel], 0);
        check("rst_done", done_o[sel], 0);
        check("rst_rdat", rdat_o[sel], 0);
    endtask

    // Called right after rst is released on a falling edge.
    task automatic wait_init();
        int  n = 0;
        int  ready_hits = 0;
        bit  seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (ready_o[1] || ready_o[0]) ready_hits++;
            if (done_o[1]) seen = 1;
        end
        check("init_cycles", n, 16);
        check("init_no_ready", ready_hits, 0);
        check("init_done_gap0", done_o[0], 1);
        check("init_done_busy", busy_o[1], 0);
        @(negedge clk);
        check("init_done_one_cycle", done_o[1], 0);
        check("init_idle_state", state_o[1], ST_IDLE);
        check("init_idle_busy", busy_o[1], 0);
    endtask

    task automatic sweep(input int sel, input logic rd, input logic [DW-1:0] base,
                         input logic [DW-1:0] step, input bit noise, input int abort_at,
                         input int exp_first, input int exp_last, input int exp_done);
        int            rel = 0;
        int            n = 0;
        int            first = -1;
        int            last = -1;
        int            prev = -1;
        int            done_rel = -1;
        int            bad_space = 0;
        int            overlap = 0;
        int            busy_hits = 0;
        int            spacing = exp_first;
        logic [DW-1:0] last_rd = '0;
        logic [DW-1:0] expv;
        if (rd) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) begin
                exp_q.push_back(exp_mem[i] ^ ((FAULT_ON && i == FA) ? 16'h0008 : 16'h0000));
            end
        end
        @(negedge clk);
        rnw_v        = rd;
        wdat_v       = base;
        start_v[sel] = 1'b1;
        for (int i = 0; i < 200 && done_rel < 0; i++) begin
            @(negedge clk);
            rel++;
            start_v[sel] = noise && (state_o[sel] != ST_IDLE);
            wdat_v       = base + step * 16'(n);
            if (ready_o[sel] && done_o[sel]) overlap++;
            if (ready_o[sel]) begin
                if (abort_at == n + 1) begin
                    start_v[sel] = 1'b0;
                    rst = 1'b1;
                    #1;
                    check_reset_outputs(sel);
                    return;
                end
                if (rd) begin
                    if (exp_q.size() == 0) begin
                        check("rd_extra_word", 1, 0);
                    end else begin
                        expv = exp_q.pop_front();
                        check("rdat_word", rdat_o[sel], expv);
                    end
                    last_rd = rdat_o[sel];
                end else begin
                    exp_mem[n] = wdat_v;
                end
                if (prev >= 0 && (rel - prev) != spacing) bad_space++;
                if (first < 0) first = rel;
                prev = rel;
                last = rel;
                n++;
            end
            if (done_o[sel]) done_rel = rel;
        end
        // With noise on, start stays high across the done cycle and must still be dropped.
        @(negedge clk);
        start_v[sel] = 1'b0;
        check("ready_count", n, 16);
        check("first_ready", first, exp_first);
        check("last_ready", last, exp_last);
        check("done_cycle", done_rel, exp_done);
        check("strobe_spacing", bad_space, 0);
        check("ready_done_overlap", overlap, 0);
        check("post_idle_state", state_o[sel], ST_IDLE);
        if (rd) begin
            check("rd_all_consumed", exp_q.size(), 0);
            check("rdat_hold", rdat_o[sel], last_rd);
        end
        if (noise) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (busy_o[sel]) busy_hits++;
            end
            check("no_queued_start", busy_hits, 0);
        end
    endtask

    initial begin
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        rnw_v      = 1'b0;
        wdat_v     = '0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs(1);
        check_reset_outputs(0);
        rst = 1'b0;
        wait_init();
        foreach (exp_mem[i]) exp_mem[i] = '0;

        // Cleared RAM on both instances, with first/last/done timing for GAP=1 and GAP=0.
        sweep(1, 1'b1, 16'h0000, 16'h0000, 1'b0, 0, 3, 48, 49);
        sweep(0, 1'b1, 16'h0000, 16'h0000, 1'b0, 0, 2, 32, 33);

        // Incrementing pattern written then read back in order.
        sweep(1, 1'b0, 16'hA000, 16'h0001, 1'b0, 0, 3, 48, 49);
        sweep(1, 1'b1, 16'h0000, 16'h0000, 1'b0, 0, 3, 48, 49);

        // Start held high throughout a busy write sweep must not restart or extend it.
        sweep(1, 1'b0, 16'hB000, 16'h0001, 1'b1, 0, 3, 48, 49);
        sweep(1, 1'b1, 16'h0000, 16'h0000, 1'b0, 0, 3, 48, 49);

        // Reset on the 7th write strobe: outputs reset at once, INIT clears the RAM again.
        sweep(1, 1'b0, 16'hC000, 16'h0001, 1'b0, 7, 3, 48, 49);
        check_reset_outputs(0);
        @(negedge clk);
        rst = 1'b0;
        wait_init();
        foreach (exp_mem[i]) exp_mem[i] = '0;
        sweep(1, 1'b1, 16'h0000, 16'h0000, 1'b0, 0, 3, 48, 49);

        // Constant 0x00FF; with fault injection word 5 reads 0x00F7 on every pass.
        sweep(1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 0, 3, 48, 49);
        sweep(1, 1'b1, 16'h0000, 16'h0000, 1'b0, 0, 3, 48, 49);
        sweep(1, 1'b1, 16'h0000, 16'h0000, 1'b0, 0, 3, 48, 49);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
